// File: rtl/store_buffer.sv
// store_buffer: lane-shifting store FIFO draining to data memory with load-hazard detection
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic [3:0]    st_wen,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_data,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [31:0]   ld_addr,
  output logic          ld_hazard,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic [31:0]   mem_addr,
  output logic [3:0]    mem_wen,
  output logic [31:0]   mem_din,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [29:0] q_addr [DEPTH];
  logic [3:0] q_wen [DEPTH];
  logic [31:0] q_data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0] wptr, rptr;
  logic [4:0] sh;
  logic enq, deq, hit, unused_lsb;
  assign unused_lsb = ^{st_addr[1:0], ld_addr[1:0]};
  assign empty = count == '0;
  assign st_ready = !rst && count != CW'(DEPTH);
  assign mem_req = !rst && !empty;
  assign enq = st_valid && st_ready && st_wen != 4'b0;
  assign deq = mem_req && mem_ack;
  assign sh = st_wen[0] ? 5'd0 : st_wen[1] ? 5'd8 : st_wen[2] ? 5'd16 : 5'd24;
  assign mem_addr = empty ? 32'b0 : {q_addr[rptr], 2'b00};
  assign mem_wen = empty ? 4'b0 : q_wen[rptr];
  assign mem_din = empty ? 32'b0 : q_data[rptr];
  assign ld_hazard = !rst && ld_valid && hit;
  always_comb begin
    hit = enq && st_addr[31:2] == ld_addr[31:2];
    for (int i = 0; i < DEPTH; i++) hit = hit || (vld[i] && q_addr[i] == ld_addr[31:2]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      vld <= '0;
    end else begin
      if (enq) begin
        vld[wptr] <= 1'b1;
        wptr <= wptr + 1'b1;
      end
      if (deq) begin
        vld[rptr] <= 1'b0;
        rptr <= rptr + 1'b1;
      end
      count <= count + CW'(enq) - CW'(deq);
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      q_addr[wptr] <= st_addr[31:2];
      q_wen[wptr] <= st_wen;
      q_data[wptr] <= st_data << sh;
    end
  end
endmodule
